// File: rtl/reg_sequencer.sv
// Four-state instruction sequencer driving an external 4x32 register file.
// One instruction per IDLE->READ->EXEC->WB pass; the register file has a one-cycle read latency.
module reg_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [1:0]  rf_addr_a,
    output logic [1:0]  rf_addr_b,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_data_a,
    input  logic [31:0] rf_data_b,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        flag_zero,
    output logic        flag_carry,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  opcode_r;
    logic [7:0]  imm_r;

    logic [32:0] alu_s;
    logic        alu_carry_s;
    logic        alu_writes_s;
    logic        alu_illegal_s;

    // ALU: 33-bit result so ADD carry-out falls out of bit 32
    always_comb begin
        alu_s         = 33'd0;
        alu_carry_s   = 1'b0;
        alu_writes_s  = 1'b1;
        alu_illegal_s = 1'b0;
        case (opcode_r)
            4'd0: alu_writes_s = 1'b0;
            4'd1: alu_s = {25'd0, imm_r};
            4'd2: alu_s = {1'b0, rf_data_b};
            4'd3: begin
                alu_s       = {1'b0, rf_data_a} + {1'b0, rf_data_b};
                alu_carry_s = alu_s[32];
            end
            4'd4: begin
                alu_s       = {1'b0, rf_data_a} - {1'b0, rf_data_b};
                alu_carry_s = (rf_data_a < rf_data_b);
            end
            4'd5: alu_s = {1'b0, rf_data_a & rf_data_b};
            4'd6: alu_s = {1'b0, rf_data_a | rf_data_b};
            4'd7: alu_s = {1'b0, rf_data_a ^ rf_data_b};
            4'd8: alu_s = {1'b0, rf_data_a << rf_data_b[4:0]};
            4'd9: alu_s = {1'b0, rf_data_a >> rf_data_b[4:0]};
            default: begin
                alu_writes_s  = 1'b0;
                alu_illegal_s = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            opcode_r     <= 4'd0;
            imm_r        <= 8'd0;
            instr_ready  <= 1'b1;
            rf_addr_a    <= 2'd0;
            rf_addr_b    <= 2'd0;
            rf_we        <= 1'b0;
            rf_wdata     <= 32'd0;
            result       <= 32'd0;
            result_valid <= 1'b0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rf_we        <= 1'b0;
                    result_valid <= 1'b0;
                    illegal      <= 1'b0;
                    if (instr_valid) begin
                        opcode_r    <= instr[15:12];
                        imm_r       <= instr[7:0];
                        rf_addr_a   <= instr[11:10];
                        rf_addr_b   <= instr[9:8];
                        instr_ready <= 1'b0;
                        state_r     <= ST_READ;
                    end else begin
                        instr_ready <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    instr_ready <= 1'b0;
                    state_r     <= ST_EXEC;
                end
                ST_EXEC: begin
                    // NOP and illegal opcodes leave alu_s at zero and clear both flags
                    rf_wdata     <= alu_s[31:0];
                    rf_we        <= alu_writes_s;
                    result       <= alu_s[31:0];
                    flag_zero    <= alu_writes_s && (alu_s[31:0] == 32'd0);
                    flag_carry   <= alu_carry_s;
                    illegal      <= alu_illegal_s;
                    result_valid <= 1'b1;
                    instr_ready  <= 1'b0;
                    state_r      <= ST_WB;
                end
                ST_WB: begin
                    rf_we        <= 1'b0;
                    result_valid <= 1'b0;
                    illegal      <= 1'b0;
                    instr_ready  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    rf_we        <= 1'b0;
                    result_valid <= 1'b0;
                    illegal      <= 1'b0;
                    instr_ready  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: behavioural register file, directed table, corner sequences
// and randomized instructions checked against an arithmetic reference model.
module tb_reg_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [1:0]  rf_addr_a;
    logic [1:0]  rf_addr_b;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic [31:0] result;
    logic        result_valid;
    logic        flag_zero;
    logic        flag_carry;
    logic        illegal;

    reg_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .result(result), .result_valid(result_valid), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file: synchronous read, no reset
    logic [31:0] rf_mem [4];
    int          we_cnt = 0;
    always @(posedge clk) begin
        if (rf_we === 1'b1) begin
            rf_mem[rf_addr_a] <= rf_wdata;
            we_cnt <= we_cnt + 1;
        end
        rf_data_a <= rf_mem[rf_addr_a];
        rf_data_b <= rf_mem[rf_addr_b];
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_rf [4];
    logic [3:0]  model_known = 4'd0;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [7:0]  imm;
        logic [31:0] exp_res;
        logic        exp_z;
        logic        exp_c;
        logic        exp_ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Reference: opcode semantics from plain wide arithmetic
    task automatic ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] imm, output logic [31:0] r, output logic z,
                            output logic c, output logic ill, output logic w);
        longint unsigned wide;
        r = 32'd0; c = 1'b0; ill = 1'b0; w = 1'b1;
        if (op == 4'd1) r = {24'd0, imm};
        else if (op == 4'd2) r = b;
        else if (op == 4'd3) begin
            wide = longint'(a) + longint'(b);
            r = wide[31:0];
            c = (wide >= 64'h1_0000_0000);
        end else if (op == 4'd4) begin
            r = a - b;
            c = (a < b);
        end else if (op == 4'd5) r = a & b;
        else if (op == 4'd6) r = a | b;
        else if (op == 4'd7) r = a ^ b;
        else if (op == 4'd8) r = a << (b % 32);
        else if (op == 4'd9) r = a >> (b % 32);
        else begin
            w = 1'b0;
            ill = (op >= 4'd10);
        end
        z = w && (r == 32'd0);
    endtask

    task automatic chk_rf(input string name);
        for (int i = 0; i < 4; i++) begin
            if (model_known[i]) chk($sformatf("%s_r%0d", name, i), rf_mem[i], model_rf[i]);
        end
    endtask

    // Issue one instruction and check the full IDLE..WB pass
    task automatic do_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [7:0] imm, input logic [31:0] er, input logic ez,
                            input logic ec, input logic ei);
        int   n;
        int   we0;
        logic w;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_timeout", {31'd0, n >= 20}, 32'd0);
        instr = mk(op, rd, rs, imm);
        instr_valid = 1'b1;
        we0 = we_cnt;
        tick();
        instr_valid = 1'b0;
        chk("ready_low_read", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("rv_early_exec", {31'd0, result_valid}, 32'd0);
        chk("we_early_exec", {31'd0, rf_we}, 32'd0);
        tick();
        w = (op >= 4'd1) && (op <= 4'd9);
        chk("rv_wb", {31'd0, result_valid}, 32'd1);
        chk("result", result, er);
        chk("flag_zero", {31'd0, flag_zero}, {31'd0, ez});
        chk("flag_carry", {31'd0, flag_carry}, {31'd0, ec});
        chk("illegal", {31'd0, illegal}, {31'd0, ei});
        chk("we_wb", {31'd0, rf_we}, {31'd0, w});
        chk("addr_a_wb", {30'd0, rf_addr_a}, {30'd0, rd});
        tick();
        chk("rv_after", {31'd0, result_valid}, 32'd0);
        chk("ill_after", {31'd0, illegal}, 32'd0);
        chk("result_hold", result, er);
        chk("we_count", we_cnt - we0, {31'd0, w});
        if (w) begin
            model_rf[rd] = er;
            model_known[rd] = 1'b1;
        end
        chk_rf("rf");
    endtask

    vec_t vecs [12];

    initial begin
        int   acc;
        int   last;
        int   lows;
        int   we0;
        logic [15:0] tp [4];
        logic [31:0] r;
        logic z, c, ill, w;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] imm;

        vecs[0]  = '{4'd1, 2'd3, 2'd0, 8'h11, 32'h0000_0011, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd1, 2'd1, 2'd0, 8'h05, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'd1, 2'd2, 2'd0, 8'h03, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'd3, 2'd1, 2'd2, 8'h00, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd1, 2'd0, 2'd0, 8'h00, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'd1, 2'd1, 2'd0, 8'h01, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd4, 2'd0, 2'd1, 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'd4, 2'd2, 2'd2, 8'h00, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'd12, 2'd3, 2'd1, 8'h7F, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'd0, 2'd1, 2'd1, 8'hFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'd3, 2'd0, 2'd0, 8'h00, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'd8, 2'd1, 2'd3, 8'h00, 32'h0002_0000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_addr", {28'd0, rf_addr_a, rf_addr_b}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, result_valid, flag_zero, flag_carry, illegal}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_instr(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm,
                     vecs[i].exp_res, vecs[i].exp_z, vecs[i].exp_c, vecs[i].exp_ill);
        end

        // Reset during EXEC of LDI r3,0xAA: the write must never happen
        we0 = we_cnt;
        instr = mk(4'd1, 2'd3, 2'd0, 8'hAA);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstexec_ready", {31'd0, instr_ready}, 32'd1);
        chk("rstexec_rv", {31'd0, result_valid}, 32'd0);
        tick();
        tick();
        tick();
        chk("rstexec_we_count", we_cnt - we0, 32'd0);
        chk("rstexec_r3", rf_mem[3], 32'h0000_0011);

        // Reset during WB of LDI r2,0x55: the presented write still commits
        we0 = we_cnt;
        instr = mk(4'd1, 2'd2, 2'd0, 8'h55);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        chk("rstwb_in_wb", {31'd0, result_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rf[2] = 32'h0000_0055;
        chk("rstwb_r2", rf_mem[2], 32'h0000_0055);
        chk("rstwb_result", result, 32'd0);
        chk("rstwb_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        tick();
        chk("rstwb_we_count", we_cnt - we0, 32'd1);

        // instr_valid held high: one accept per 4 clocks
        tp[0] = mk(4'd1, 2'd0, 2'd0, 8'h10);
        tp[1] = mk(4'd1, 2'd1, 2'd0, 8'h20);
        tp[2] = mk(4'd1, 2'd2, 2'd0, 8'h30);
        tp[3] = mk(4'd1, 2'd3, 2'd0, 8'h11);
        acc = 0;
        last = 0;
        lows = 0;
        instr = tp[0];
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && acc < 4; cyc++) begin
            if (instr_ready === 1'b1) begin
                if (acc > 0) chk("tp_spacing", cyc - last, 32'd4);
                last = cyc;
                acc++;
                tick();
                if (acc < 4) instr = tp[acc];
                else instr_valid = 1'b0;
            end else begin
                lows++;
                tick();
            end
        end
        instr_valid = 1'b0;
        chk("tp_accepts", acc, 32'd4);
        chk("tp_ready_low", lows, 32'd9);
        tick();
        tick();
        tick();
        model_rf[0] = 32'h10;
        model_rf[1] = 32'h20;
        model_rf[2] = 32'h30;
        model_rf[3] = 32'h11;
        model_known = 4'hF;
        chk_rf("tp_rf");

        // Randomized instructions against the reference model
        for (int k = 0; k < 60; k++) begin
            op  = 4'($urandom_range(0, 15));
            rd  = 2'($urandom_range(0, 3));
            rs  = 2'($urandom_range(0, 3));
            imm = 8'($urandom_range(0, 255));
            if (k % 5 == 0) op = 4'd1;
            ref_exec(op, model_rf[rd], model_rf[rs], imm, r, z, c, ill, w);
            do_instr(op, rd, rs, imm, r, z, c, ill);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
